conv_sequencer: RTL and testbench
=================================

# conv_sequencer

Sequences one 3x3 convolution pass over the source frame buffer and writes the filtered frame into the destination frame buffer. It sits inside the processor, between the key-command controller and the two frame-buffer RAM ports. The controller pulses `start` with a kernel selection. The sequencer then walks every pixel in raster order, fetches the nine neighbourhood taps, accumulates, clamps and writes the result. It reports completion with a one-cycle `done` pulse.

## Interface
- `IMG_W`, 160, image width in pixels
- `IMG_H`, 120, image height in pixels
- `ADDR_W`, 15, frame-buffer address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H
- `PIX_W`, 3, pixel width; unsigned pixels in the range 0..7
- `clk_proc`  in  1  processor clock; one clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  pulse; accepted only in IDLE
- `abort`  in  1  level; terminates a pass
- `kernel_sel`  in  2  0 identity, 1 blur, 2 sharpen, 3 edge; latched when `start` is accepted
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at the end of a completed pass
- `src_rd`  out  1  source read strobe
- `src_addr`  out  ADDR_W  source address, y*IMG_W+x
- `src_data`  in  PIX_W  source read data, valid exactly 1 cycle after `src_rd`
- `dst_wr`  out  1  destination write strobe
- `dst_addr`  out  ADDR_W  destination address of the current pixel
- `dst_data`  out  PIX_W  filtered pixel

## Operation
- States:
  - IDLE → READ on `start`.
  - READ lasts 9 cycles, tap t=0..8 in row-major order over dy,dx ∈ {-1,0,1}.
  - READ → DRAIN (1 cycle).
  - DRAIN → WRITE (1 cycle).
  - WRITE → READ for the next pixel, or → DONE after the last pixel.
  - DONE lasts 1 cycle, then → IDLE.
- Kernels (row-major), each followed by a right shift:
  - identity: 0 0 0 / 0 1 0 / 0 0 0, shift 0
  - blur: 1 2 1 / 2 4 2 / 1 2 1, shift 4
  - sharpen: 0 -1 0 / -1 5 -1 / 0 -1 0, shift 0
  - edge: -1 -1 -1 / -1 8 -1 / -1 -1 -1, shift 0
- Accumulator:
  - 9-bit signed (range -56..112), cleared at tap 0 of each pixel.
  - Tap t's data is added in the cycle after it is read, as coeff*src_data.
- Result: arithmetic right shift, then clamp to 0..7. Negative values give 0; values >7 give 7.
- Border handling: zero padding.
  - A tap outside 0..IMG_W-1 / 0..IMG_H-1 holds `src_rd`=0 for that cycle and contributes 0.
  - The slot still consumes its cycle, so per-pixel timing is constant.
- Pixel order: x increments first; at x=IMG_W-1 it wraps to 0 and y increments. The pass ends after (IMG_W-1, IMG_H-1).
- `start` while `busy` is ignored. `kernel_sel` changes after acceptance have no effect on the current pass.
- `abort` high in any non-IDLE state:
  - next state is IDLE;
  - `dst_wr` is 0 in that cycle;
  - no `done` pulse.
- `abort` has priority over `start` in the same cycle.
- `rst` mid-pass behaves like abort. All registers return to reset values and the partial frame is left as written.

## Timing
- Reset values:
  - `busy`, `done`, `src_rd`, `dst_wr` = 0
  - `src_addr`, `dst_addr`, `dst_data` = 0
  - state IDLE, accumulator 0
- Cycle 0 is the edge at which `start` is sampled high in IDLE. `busy`=1 from cycle 1.
- Pixel p (0-based raster index) timing:
  - READ at cycles 1+11p .. 9+11p
  - DRAIN at 10+11p
  - WRITE at 11+11p, with `dst_wr`=1 and `dst_addr`=p
- Every cycle has at most one `src_rd` and at most one `dst_wr`.
- DONE occurs at cycle 1+11·IMG_W·IMG_H, with `done`=1 and `busy`=1.
- `busy`=0 from the following cycle.
- All outputs are registered; no combinational path from an input to an output.

## Test plan
Use IMG_W=4, IMG_H=3 for all scenarios.
- Identity on a src ramp (pixel p = p mod 8): start, sel=0 → dst equals src at all 12 addresses. Only centre taps are valid, so 12 `src_rd` at the interior-tap slots plus neighbours are read but weighted 0.
- Blur on an all-7 src:
  - interior (1,1) and (2,1) = 112>>4 = 7
  - corner (0,0) = 63>>4 = 3
  - edge (1,0) = 84>>4 = 5
- Edge on an all-5 src:
  - interior = 0
  - corner = 40-15 = 25, clamped to 7
- Sharpen on an all-3 src:
  - interior = 3
  - corner = 15-6 = 9, clamped to 7
- Timing:
  - first `dst_wr` at cycle 11
  - last `dst_wr` at cycle 132
  - `done` pulse exactly at cycle 133, then `busy`=0 at cycle 134
  - a second `start` at cycle 50 is ignored
  - `src_rd` never asserts for an out-of-range tap
- Abort and reset:
  - `abort` at cycle 40 → IDLE at 41; no writes after cycle 33; no `done`.
  - A new `start` then runs a full pass.
  - `rst` at cycle 60 → all outputs 0 next cycle.

Source files
------------

// File: rtl/conv_sequencer.sv
// 3x3 convolution sequencer: walks the source frame in raster order and
// writes one clamped, filtered pixel per 11-cycle slot into the destination.
module conv_sequencer #(
  parameter int IMG_W  = 160,
  parameter int IMG_H  = 120,
  parameter int ADDR_W = 15,
  parameter int PIX_W  = 3
) (
  input  logic              clk_proc,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        kernel_sel,
  output logic              busy,
  output logic              done,
  output logic              src_rd,
  output logic [ADDR_W-1:0] src_addr,
  input  logic [PIX_W-1:0]  src_data,
  output logic              dst_wr,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [PIX_W-1:0]  dst_data
);

  localparam logic [ADDR_W-1:0] XMAX = ADDR_W'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] YMAX = ADDR_W'(IMG_H - 1);
  localparam logic signed [8:0] PMAX = 9'((1 << PIX_W) - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_DRAIN, S_WRITE, S_DONE
  } state_t;

  state_t            state;
  logic [3:0]        tap, s1_tap, nt;
  logic [ADDR_W-1:0] px, py, pix, nx, ny, naddr;
  logic [1:0]        ksel;
  logic              s1_rd, s1_live, go_read, inr, last_pix;
  logic signed [8:0] acc, cf, dv, term, sum, shf;
  logic [PIX_W-1:0]  res;
  int                sx, sy;

  function automatic logic signed [4:0] coef(
    input logic [1:0] k,
    input logic [3:0] t
  );
    logic corner, centre;
    corner = (t == 4'd0) || (t == 4'd2) ||
             (t == 4'd6) || (t == 4'd8);
    centre = (t == 4'd4);
    unique case (k)
      2'd0:    coef = centre ? 5'sd1 : 5'sd0;
      2'd1:    coef = centre ? 5'sd4 :
                      (corner ? 5'sd1 : 5'sd2);
      2'd2:    coef = centre ? 5'sd5 :
                      (corner ? 5'sd0 : -5'sd1);
      default: coef = centre ? 5'sd8 : -5'sd1;
    endcase
  endfunction

  // Tap slot that the coming edge will issue, and its neighbour address.
  always_comb begin
    last_pix = (px == XMAX) && (py == YMAX);
    go_read  = 1'b0;
    nt       = '0;
    nx       = px;
    ny       = py;
    unique case (state)
      S_IDLE: begin
        go_read = start;
        nx      = '0;
        ny      = '0;
      end
      S_READ: begin
        go_read = (tap != 4'd8);
        nt      = tap + 4'd1;
      end
      S_WRITE: begin
        go_read = !last_pix;
        nx      = (px == XMAX) ? '0 : px + 1'b1;
        ny      = (px == XMAX) ? py + 1'b1 : py;
      end
      default: ;
    endcase
    sx    = int'(nx) + int'(nt % 4'd3) - 1;
    sy    = int'(ny) + int'(nt / 4'd3) - 1;
    inr   = go_read && sx >= 0 && sx < IMG_W &&
            sy >= 0 && sy < IMG_H;
    naddr = inr ? ADDR_W'(sy * IMG_W + sx) : '0;
  end

  // Returning data belongs to the tap issued one slot earlier.
  always_comb begin
    cf   = 9'(coef(ksel, s1_tap));
    dv   = s1_rd ? $signed(9'(src_data)) : '0;
    term = cf * dv;
    sum  = (s1_tap == 4'd0) ? term : acc + term;
    shf  = (ksel == 2'd1) ? (sum >>> 4) : sum;
    if (shf < 0)
      res = '0;
    else if (shf > PMAX)
      res = PIX_W'(PMAX);
    else
      res = PIX_W'(shf);
  end

  always_ff @(posedge clk_proc) begin
    if (rst) begin
      state    <= S_IDLE;
      tap      <= '0;
      px       <= '0;
      py       <= '0;
      pix      <= '0;
      ksel     <= '0;
      s1_rd    <= 1'b0;
      s1_live  <= 1'b0;
      s1_tap   <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      src_rd   <= 1'b0;
      src_addr <= '0;
      dst_wr   <= 1'b0;
      dst_addr <= '0;
      dst_data <= '0;
    end else begin
      s1_rd    <= src_rd;
      s1_live  <= (state == S_READ);
      s1_tap   <= tap;
      if (s1_live) acc <= sum;
      src_rd   <= inr && !abort;
      src_addr <= abort ? '0 : naddr;
      dst_wr   <= 1'b0;
      done     <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          S_IDLE: if (start) begin
            state <= S_READ;
            busy  <= 1'b1;
            ksel  <= kernel_sel;
            tap   <= '0;
            px    <= nx;
            py    <= ny;
            pix   <= '0;
          end
          S_READ: begin
            if (tap == 4'd8) state <= S_DRAIN;
            else tap <= nt;
          end
          S_DRAIN: begin
            state    <= S_WRITE;
            dst_wr   <= 1'b1;
            dst_addr <= pix;
            dst_data <= res;
          end
          S_WRITE: begin
            pix <= pix + 1'b1;
            if (last_pix) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_READ;
              tap   <= '0;
              px    <= nx;
              py    <= ny;
            end
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Bench for conv_sequencer on a 4x3 frame: RAM models, per-cycle
// timing reference and an arithmetic convolution model.
module tb_conv_sequencer;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = 4;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [1:0]    kernel_sel;
  logic          busy, done, src_rd, dst_wr;
  logic [AW-1:0] src_addr, dst_addr;
  logic [PW-1:0] src_data, dst_data;

  always #5 clk = ~clk;

  conv_sequencer #(
    .IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW)
  ) dut (
    .clk_proc(clk), .rst(rst), .start(start),
    .abort(abort), .kernel_sel(kernel_sel),
    .busy(busy), .done(done), .src_rd(src_rd),
    .src_addr(src_addr), .src_data(src_data),
    .dst_wr(dst_wr), .dst_addr(dst_addr),
    .dst_data(dst_data)
  );

  logic [PW-1:0] src_mem [16];
  int            dst_mem [16];
  logic          clr_dst;

  always @(posedge clk) begin
    if (src_rd) src_data <= src_mem[src_addr];
    if (clr_dst)
      for (int i = 0; i < 16; i++) dst_mem[i] <= -1;
    else if (dst_wr)
      dst_mem[dst_addr] <= int'(dst_data);
  end

  int pe = 0;
  always @(posedge clk) pe <= pe + 1;

  int total = 0;
  int bad   = 0;
  int start_pe, first_wr, last_wr, wr_cnt;
  int done_cyc, done_cnt, rd_err, busy_err, addr_err;
  bit in_pass = 0;

  int KT [4][9] = '{
    '{ 0,  0,  0,  0, 1,  0,  0,  0,  0},
    '{ 1,  2,  1,  2, 4,  2,  1,  2,  1},
    '{ 0, -1,  0, -1, 5, -1,  0, -1,  0},
    '{-1, -1, -1, -1, 8, -1, -1, -1, -1}
  };
  int SH [4] = '{0, 4, 0, 0};

  function automatic int model(input int k, input int x, input int y);
    int s, nxp, nyp;
    s = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        nxp = x + dx;
        nyp = y + dy;
        if (nxp >= 0 && nxp < W && nyp >= 0 && nyp < H)
          s += KT[k][(dy + 1) * 3 + dx + 1] * int'(src_mem[nyp * W + nxp]);
      end
    s = s >>> SH[k];
    if (s < 0) s = 0;
    if (s > 7) s = 7;
    return s;
  endfunction

  // Cycle c is what is visible just before the c-th edge after start.
  always @(negedge clk) if (in_pass) begin
    int c, p, s, tx, ty, ea;
    bit er;
    c = pe - start_pe;
    if (c >= 1) begin
      if (dst_wr) begin
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        wr_cnt++;
        if (c != 11 + 11 * int'(dst_addr)) addr_err++;
      end
      if (done) begin
        done_cyc = c;
        done_cnt++;
      end
      if (busy !== (c <= 11 * N + 1)) busy_err++;
      er = 1'b0;
      ea = 0;
      if (c <= 11 * N) begin
        p = (c - 1) / 11;
        s = (c - 1) % 11;
        tx = p % W + s % 3 - 1;
        ty = p / W + s / 3 - 1;
        if (s < 9 && tx >= 0 && tx < W && ty >= 0 && ty < H) begin
          er = 1'b1;
          ea = ty * W + tx;
        end
      end
      if (src_rd !== er || (er && int'(src_addr) != ea)) rd_err++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_pass(input int k);
    @(negedge clk);
    clr_dst = 1'b1;
    @(negedge clk);
    clr_dst  = 1'b0;
    first_wr = -1;
    last_wr  = -1;
    wr_cnt   = 0;
    done_cyc = -1;
    done_cnt = 0;
    rd_err   = 0;
    busy_err = 0;
    addr_err = 0;
    kernel_sel = 2'(k);
    start    = 1'b1;
    start_pe = pe;
    in_pass  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    kernel_sel = 2'($urandom);
  endtask

  task automatic run_to(input int c);
    while (pe - start_pe < c) @(negedge clk);
  endtask

  task automatic check_pass(input int k, input string nm);
    check({nm, "_first_wr"}, first_wr, 11);
    check({nm, "_last_wr"}, last_wr, 11 * N);
    check({nm, "_wr_cnt"}, wr_cnt, N);
    check({nm, "_done_cyc"}, done_cyc, 11 * N + 1);
    check({nm, "_done_cnt"}, done_cnt, 1);
    check({nm, "_busy"}, busy_err, 0);
    check({nm, "_src_rd"}, rd_err, 0);
    check({nm, "_dst_addr"}, addr_err, 0);
    for (int p = 0; p < N; p++)
      check($sformatf("%s_px%0d", nm, p), dst_mem[p], model(k, p % W, p / W));
  endtask

  task automatic full_pass(input int k, input string nm, input bit restart);
    start_pass(k);
    if (restart) begin
      run_to(50);
      start = 1'b1;
      kernel_sel = 2'(k + 1);
      @(negedge clk);
      start = 1'b0;
    end
    run_to(11 * N + 3);
    in_pass = 1'b0;
    check_pass(k, nm);
  endtask

  initial begin
    int k;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    kernel_sel = '0;
    clr_dst = 1'b0;
    for (int i = 0; i < 16; i++) src_mem[i] = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          int'({busy, done, src_rd, dst_wr, src_addr, dst_addr, dst_data}), 0);
    rst = 1'b0;

    for (int i = 0; i < N; i++) src_mem[i] = PW'(i % 8);
    full_pass(0, "ident", 1'b0);

    for (int i = 0; i < N; i++) src_mem[i] = 3'd7;
    full_pass(1, "blur", 1'b0);
    check("blur_int11", dst_mem[5], 7);
    check("blur_int21", dst_mem[6], 7);
    check("blur_corner", dst_mem[0], 3);
    check("blur_edge10", dst_mem[1], 5);

    for (int i = 0; i < N; i++) src_mem[i] = 3'd5;
    full_pass(3, "edge", 1'b0);
    check("edge_int", dst_mem[5], 0);
    check("edge_corner", dst_mem[0], 7);

    for (int i = 0; i < N; i++) src_mem[i] = 3'd3;
    full_pass(2, "sharp", 1'b0);
    check("sharp_int", dst_mem[5], 3);
    check("sharp_corner", dst_mem[0], 7);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N; i++) src_mem[i] = PW'($urandom);
      k = int'($urandom_range(0, 3));
      full_pass(k, $sformatf("rand%0d_k%0d", r, k), r[0]);
    end

    for (int i = 0; i < N; i++) src_mem[i] = PW'($urandom);
    start_pass(2);
    run_to(40);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", int'(busy), 0);
    run_to(80);
    in_pass = 1'b0;
    check("abort_wr_cnt", wr_cnt, 3);
    check("abort_last_wr", last_wr, 33);
    check("abort_done_cnt", done_cnt, 0);
    check("abort_px2", dst_mem[2], model(2, 2, 0));
    check("abort_px3", dst_mem[3], -1);

    k = int'($urandom_range(0, 3));
    full_pass(k, "post_abort", 1'b0);

    start_pass(1);
    run_to(60);
    rst = 1'b1;
    @(negedge clk);
    check("rst_outputs",
          int'({busy, done, src_rd, dst_wr, src_addr, dst_addr, dst_data}), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    in_pass = 1'b0;
    check("rst_done_cnt", done_cnt, 0);
    check("rst_busy", int'(busy), 0);

    for (int i = 0; i < N; i++) src_mem[i] = PW'($urandom);
    full_pass(3, "post_rst", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
